// File: rtl/fpg8_pkg.sv
// Shared FPG8 definitions: datapath word width, memory responder states,
// default RAM depth and the address range test used by the responder.
package fpg8_pkg;

    localparam int unsigned WORD_W        = 16;
    localparam int unsigned DEFAULT_DEPTH = 256;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } mem_state_e;

    // Full-width compare so DEPTH=65536 (no spare upper address bits) works.
    function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                           input int unsigned       depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: one shared address, synchronous write, synchronous
// read into an output register. No reset on contents or read register.
module mem_array
    import fpg8_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Write commits at the edge; read data registered for next cycle.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the FPG8 datapath bus: MAR/MDR, RAM strobes,
// power-on clear, program loader and sticky error flags.
// Build option MEM_CLEAR_EN: when defined, reset enters CLEAR and zeroes
// the RAM over DEPTH cycles; when undefined, reset enters LOAD directly.
module mem_responder
    import fpg8_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] bus_in,
    output logic [WORD_W-1:0] bus_out,
    output logic              bus_drive,
    input  logic              MAR_in,
    input  logic              MDR_in,
    input  logic              MDR_out,
    input  logic              RAM_enable_read,
    input  logic              RAM_enable_write,
    input  logic              init_valid,
    input  logic [WORD_W-1:0] init_addr,
    input  logic [WORD_W-1:0] init_data,
    input  logic              init_last,
    output logic              init_ready,
    output logic              mem_ready,
    output logic              addr_fault,
    output logic              protocol_err
);

`ifdef MEM_CLEAR_EN
    localparam mem_state_e RESET_STATE = CLEAR;
    logic [ADDR_W-1:0] r_clr_cnt;
`else
    localparam mem_state_e RESET_STATE = LOAD;
`endif

    mem_state_e        r_state;
    mem_state_e        w_state_nxt;
    logic [WORD_W-1:0] r_mar;
    logic [WORD_W-1:0] r_mdr;
    logic              r_mdr_from_ram;
    logic              r_addr_fault;
    logic              r_protocol_err;

    logic [WORD_W-1:0] w_ea;
    logic              w_ea_ok;
    logic              w_init_ok;
    logic              w_strobe_any;
    logic              w_access;
    logic [WORD_W-1:0] w_mdr;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_ea         = MAR_in ? bus_in : r_mar;
    assign w_ea_ok      = addr_in_range(w_ea, DEPTH);
    assign w_init_ok    = addr_in_range(init_addr, DEPTH);
    assign w_access     = RAM_enable_read | RAM_enable_write;
    assign w_strobe_any = MAR_in | MDR_in | MDR_out | w_access;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM port mux: clear counter, loader or bus side.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        case (r_state)
`ifdef MEM_CLEAR_EN
            CLEAR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = r_clr_cnt;
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = LOAD;
                end
            end
`endif
            LOAD: begin
                if (init_valid) begin
                    w_ram_we    = w_init_ok;
                    w_ram_addr  = init_addr[ADDR_W-1:0];
                    w_ram_wdata = init_data;
                    if (init_last) begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                w_ram_addr  = w_ea[ADDR_W-1:0];
                w_ram_wdata = bus_in;
                w_ram_we    = RAM_enable_write & w_ea_ok;
                // A simultaneous write takes the port; MDR then takes bus_in.
                w_ram_re    = RAM_enable_read & ~RAM_enable_write & w_ea_ok;
            end
            default: ;
        endcase
    end

`ifdef MEM_CLEAR_EN
    // Clear counter walks every word once while in CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
        end
    end
`endif

    // MAR, MDR and sticky flags. MDR is the RAM read register when
    // r_mdr_from_ram is set, otherwise r_mdr; this keeps read latency at one
    // cycle with a synchronous-read array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mar          <= '0;
            r_mdr          <= '0;
            r_mdr_from_ram <= 1'b0;
            r_addr_fault   <= 1'b0;
            r_protocol_err <= 1'b0;
        end else if (r_state == RUN) begin
            if (MAR_in) begin
                r_mar <= bus_in;
            end
            if (w_access && !w_ea_ok) begin
                r_addr_fault <= 1'b1;
            end
            if (RAM_enable_read && RAM_enable_write) begin
                r_protocol_err <= 1'b1;
                r_mdr          <= bus_in;
                r_mdr_from_ram <= 1'b0;
            end else if (RAM_enable_read) begin
                r_mdr          <= '0;
                r_mdr_from_ram <= w_ea_ok;
            end else if (MDR_in) begin
                r_mdr          <= bus_in;
                r_mdr_from_ram <= 1'b0;
            end
        end else begin
            if (w_strobe_any) begin
                r_protocol_err <= 1'b1;
            end
            if (r_state == LOAD && init_valid && !w_init_ok) begin
                r_addr_fault <= 1'b1;
            end
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem_array (
        .i_clk  (clk),
        .i_we   (w_ram_we),
        .i_re   (w_ram_re),
        .i_addr (w_ram_addr),
        .i_wdata(w_ram_wdata),
        .o_rdata(w_ram_rdata)
    );

    assign w_mdr        = r_mdr_from_ram ? w_ram_rdata : r_mdr;
    assign bus_out      = w_mdr;
    assign bus_drive    = MDR_out & (r_state == RUN);
    assign init_ready   = (r_state == LOAD) & ~reset;
    assign mem_ready    = (r_state == RUN);
    assign addr_fault   = r_addr_fault;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder (DEPTH=16). Honours MEM_CLEAR_EN like the design.
module tb_mem_responder;

    localparam int DEPTH = 16;
`ifdef MEM_CLEAR_EN
    localparam bit CLR_BUILD = 1'b1;
`else
    localparam bit CLR_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_drive;
    logic        MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write;
    logic        init_valid;
    logic [15:0] init_addr;
    logic [15:0] init_data;
    logic        init_last;
    logic        init_ready, mem_ready, addr_fault, protocol_err;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: phase 0 = clearing, 1 = loading, 2 = running.
    int          m_phase;
    int          m_clr_idx;
    logic [15:0] m_mar;
    logic [15:0] m_mdr;
    bit          m_mdr_known;
    bit          m_fault;
    bit          m_perr;
    logic [15:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];

    mem_responder #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .bus_drive       (bus_drive),
        .MAR_in          (MAR_in),
        .MDR_in          (MDR_in),
        .MDR_out         (MDR_out),
        .RAM_enable_read (RAM_enable_read),
        .RAM_enable_write(RAM_enable_write),
        .init_valid      (init_valid),
        .init_addr       (init_addr),
        .init_data       (init_data),
        .init_last       (init_last),
        .init_ready      (init_ready),
        .mem_ready       (mem_ready),
        .addr_fault      (addr_fault),
        .protocol_err    (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        MAR_in = 0; MDR_in = 0; MDR_out = 0;
        RAM_enable_read = 0; RAM_enable_write = 0;
        init_valid = 0; init_last = 0; init_addr = '0; init_data = '0;
        bus_in = '0;
    endtask

    task automatic model_reset();
        m_phase     = CLR_BUILD ? 0 : 1;
        m_clr_idx   = 0;
        m_mar       = '0;
        m_mdr       = '0;
        m_mdr_known = 1;
        m_fault     = 0;
        m_perr      = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    endtask

    // Apply the rules for one clock edge given the inputs currently driven.
    task automatic model_step();
        bit any;
        int ea;
        bit ok;
        any = MAR_in | MDR_in | MDR_out | RAM_enable_read | RAM_enable_write;
        if (m_phase == 0) begin
            if (any) m_perr = 1;
            m_mem[m_clr_idx]   = 16'h0000;
            m_known[m_clr_idx] = 1;
            m_clr_idx++;
            if (m_clr_idx == DEPTH) m_phase = 1;
        end else if (m_phase == 1) begin
            if (any) m_perr = 1;
            if (init_valid) begin
                if (int'(init_addr) < DEPTH) begin
                    m_mem[int'(init_addr)]   = init_data;
                    m_known[int'(init_addr)] = 1;
                end else begin
                    m_fault = 1;
                end
                if (init_last) m_phase = 2;
            end
        end else begin
            ea = MAR_in ? int'(bus_in) : int'(m_mar);
            ok = (ea < DEPTH);
            if ((RAM_enable_read || RAM_enable_write) && !ok) m_fault = 1;
            if (RAM_enable_write && ok) begin
                m_mem[ea]   = bus_in;
                m_known[ea] = 1;
            end
            if (RAM_enable_read && RAM_enable_write) begin
                m_perr = 1;
                m_mdr = bus_in; m_mdr_known = 1;
            end else if (RAM_enable_read) begin
                if (ok) begin
                    m_mdr = m_mem[ea]; m_mdr_known = m_known[ea];
                end else begin
                    m_mdr = '0; m_mdr_known = 1;
                end
            end else if (MDR_in) begin
                m_mdr = bus_in; m_mdr_known = 1;
            end
            if (MAR_in) m_mar = bus_in;
        end
    endtask

    task automatic compare_outs();
        bit exp_drive;
        exp_drive = MDR_out && (m_phase == 2);
        check_eq("init_ready", init_ready, m_phase == 1);
        check_eq("mem_ready", mem_ready, m_phase == 2);
        check_eq("addr_fault", addr_fault, m_fault);
        check_eq("protocol_err", protocol_err, m_perr);
        check_eq("bus_drive", bus_drive, exp_drive);
        if (exp_drive && m_mdr_known) check_eq("bus_out", bus_out, m_mdr);
    endtask

    // Inputs are set around posedge+1; outputs sampled at posedge+2.
    task automatic cycle();
        #1;
        compare_outs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        #1;
        check_eq("rst_bus_out", bus_out, 16'h0000);
        check_eq("rst_bus_drive", bus_drive, 0);
        check_eq("rst_init_ready", init_ready, 0);
        check_eq("rst_mem_ready", mem_ready, 0);
        check_eq("rst_addr_fault", addr_fault, 0);
        check_eq("rst_protocol_err", protocol_err, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_wait();
        for (int i = 0; i < DEPTH + 2 && m_phase == 0; i++) cycle();
        #1;
        check_eq("init_ready_after_clear", init_ready, 1);
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d, input bit last);
        init_valid = 1; init_addr = a; init_data = d; init_last = last;
        cycle();
        idle();
    endtask

    task automatic bus_read(input logic [15:0] a);
        MAR_in = 1; RAM_enable_read = 1; bus_in = a;
        cycle();
        idle();
    endtask

    // Drive MDR_out for one cycle and check bus_out against a fixed value.
    task automatic show_mdr(input string tag, input logic [15:0] exp);
        MDR_out = 1;
        #1;
        check_eq(tag, bus_out, exp);
        check_eq({tag, "_drive"}, bus_drive, 1);
        cycle();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        apply_reset();
        clear_wait();

        // Two words, then reset in the middle of LOAD.
        load_word(16'd1, 16'hA1A1, 0);
        load_word(16'd9, 16'h9999, 0);
        apply_reset();
        clear_wait();

        for (int i = 0; i < 6; i++) begin
            load_word(16'($urandom_range(10, 15)), 16'($urandom), 0);
            if ($urandom_range(0, 1) == 1) cycle();
        end
        load_word(16'd3, 16'h1234, 1);
        #1;
        check_eq("mem_ready_after_last", mem_ready, 1);

        bus_read(16'd5);
        if (CLR_BUILD) show_mdr("read5_zero", 16'h0000);
        bus_read(16'd3);
        show_mdr("read3", 16'h1234);

        MAR_in = 1; bus_in = 16'd7; cycle(); idle();
        MDR_in = 1; RAM_enable_write = 1; bus_in = 16'hBEEF; cycle(); idle();
        RAM_enable_read = 1; cycle(); idle();
        show_mdr("read7", 16'hBEEF);
        check_eq("no_fault_yet", addr_fault, 0);

        if (CLR_BUILD) begin
            bus_read(16'd1);
            show_mdr("after_reset_w1", 16'h0000);
            bus_read(16'd9);
            show_mdr("after_reset_w9", 16'h0000);
        end

        bus_read(16'h0010);
        show_mdr("oob_read", 16'h0000);
        check_eq("oob_fault", addr_fault, 1);
        bus_read(16'd3);
        show_mdr("inrange_after_oob", 16'h1234);
        check_eq("fault_sticky", addr_fault, 1);

        MAR_in = 1; bus_in = 16'd2; cycle(); idle();
        RAM_enable_read = 1; RAM_enable_write = 1; bus_in = 16'h00AA; cycle(); idle();
        show_mdr("rdwr_mdr", 16'h00AA);
        check_eq("rdwr_perr", protocol_err, 1);
        RAM_enable_read = 1; cycle(); idle();
        show_mdr("rdwr_ram2", 16'h00AA);

        MDR_out = 1; MDR_in = 1; bus_in = 16'h5555;
        #1;
        check_eq("out_in_old", bus_out, 16'h00AA);
        cycle(); idle();
        show_mdr("out_in_new", 16'h5555);

        for (int i = 0; i < 300; i++) begin
            int pick;
            MAR_in           = ($urandom_range(0, 9) < 3);
            RAM_enable_read  = ($urandom_range(0, 9) < 3);
            RAM_enable_write = ($urandom_range(0, 9) < 2);
            MDR_in           = ($urandom_range(0, 9) < 2);
            MDR_out          = ($urandom_range(0, 9) < 5);
            if (MAR_in) begin
                pick = $urandom_range(0, 9);
                if (pick < 8)       bus_in = 16'($urandom_range(0, 15));
                else if (pick == 8) bus_in = 16'($urandom_range(16, 255));
                else                bus_in = 16'h8000 | 16'($urandom_range(0, 15));
            end else begin
                bus_in = 16'($urandom);
            end
            cycle();
        end
        idle();

        // Strobes outside RUN, then an out-of-range loader word.
        apply_reset();
        MDR_out = 1; RAM_enable_read = 1;
        cycle();
        idle();
        cycle();
        check_eq("perr_outside_run", protocol_err, 1);
        clear_wait();
        load_word(16'h0040, 16'h1111, 0);
        load_word(16'h8002, 16'h2222, 0);
        cycle();
        check_eq("load_fault", addr_fault, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the FPG8 datapath bus. It owns the MAR and MDR registers and a single-port word RAM, and carries out the MAR_in, MDR_in, MDR_out, RAM_enable_read and RAM_enable_write strobes that the control unit issues during fetch, load/store, trap and timer-vector sequences. After reset it clears the RAM, then accepts a program image over a valid/ready load port, then enters service mode.

## Interface
- DEPTH, 256: RAM words; power of two, 2..65536.
- ADDR_W, $clog2(DEPTH): RAM index width.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_in  in  16  shared datapath bus value this cycle.
- bus_out  out  16  MDR value; valid when bus_drive=1.
- bus_drive  out  1  equals MDR_out while in RUN; 0 otherwise.
- MAR_in, MDR_in, MDR_out, RAM_enable_read, RAM_enable_write  in  1 each  control-unit strobes, single-cycle.
- init_valid  in  1  loader word valid.
- init_addr  in  16  loader word address.
- init_data  in  16  loader word data.
- init_last  in  1  marks final loader word.
- init_ready  out  1  loader word accepted this cycle.
- mem_ready  out  1  high in RUN; gates release of the control unit from reset.
- addr_fault  out  1  sticky; an access used an address ≥ DEPTH.
- protocol_err  out  1  sticky; illegal strobe combination, or strobes outside RUN.

## Operation
- States: CLEAR → LOAD → RUN. The reset state is CLEAR.
- CLEAR: a counter writes 0 to RAM[0..DEPTH-1], one word per cycle. After word DEPTH-1 is written, the state moves to LOAD.
- LOAD: init_ready=1. A word is accepted when init_valid=1, and RAM[init_addr] ← init_data. If init_addr ≥ DEPTH, the write is dropped and addr_fault is set. Accepting a word with init_last=1 moves the state to RUN.
- RUN: the effective address is ea = MAR_in ? bus_in : MAR.
  - MAR_in: MAR ← bus_in.
  - RAM_enable_read: MDR ← RAM[ea].
  - RAM_enable_write: RAM[ea] ← bus_in.
  - MDR_in with no read: MDR ← bus_in. This covers the store and push sequences.
  - MDR_out: bus_drive=1 and bus_out=MDR, combinationally, in the same cycle.
  - If ea[15:ADDR_W] ≠ 0, the access is suppressed: a read loads MDR with 0, a write is dropped. addr_fault is set.
- Simultaneous events:
  - Read and write in the same cycle: the write is performed, MDR ← bus_in, and protocol_err is set.
  - MDR_in together with read: the read data wins. protocol_err is not set.
  - MDR_out together with MDR_in: bus_out shows the old MDR, and the new value is visible next cycle.
- Any strobe outside RUN is ignored and sets protocol_err.
- Once in RUN, the block stays in RUN until reset.

## Timing
- Reset values: MAR=0, MDR=0, clear counter=0, state=CLEAR, bus_drive=0, bus_out=0, init_ready=0, mem_ready=0, addr_fault=0, protocol_err=0.
- Reset asserted mid-operation aborts everything immediately. RAM contents are then undefined until the next CLEAR completes.
- Read latency is 1 cycle. Read data is in MDR at the next edge and can be driven by MDR_out in the following cycle. Example: F1 read followed by F2 MDR_out.
- Writes commit at the edge of the strobe cycle.
- CLEAR lasts exactly DEPTH cycles. init_ready rises on the cycle after the last clear write.
- mem_ready rises on the cycle after the init_last word is accepted.

## Configuration
- MEM_CLEAR_EN defined: behaviour as above. CLEAR takes DEPTH cycles and RAM starts all-zero.
- MEM_CLEAR_EN undefined: the CLEAR state and its counter are removed. Reset enters LOAD directly, with init_ready=1 on the first cycle after reset. Unloaded words are undefined (X in simulation).

## Structure
- Shared package fpg8_pkg:
  - WORD_W=16.
  - The state enum {CLEAR, LOAD, RUN}.
  - Default DEPTH.
- One sub-module, mem_array: a single-port synchronous-read RAM with one write port. The write port is muxed between the clear counter, the loader and the bus.
- MAR, MDR, the FSM and the flags live in the top module.

## Test plan
- Reset with DEPTH=16, MEM_CLEAR_EN defined → mem_ready=0 for 16 cycles of CLEAR, then init_ready=1. A read of address 5 after load returns 0x0000.
- Load 0x1234 at address 3 with init_last=1 → mem_ready=1 the next cycle. Then MAR_in+read with bus_in=3, followed by MDR_out → bus_out=0x1234 and bus_drive=1 in the second cycle.
- MAR_in with bus_in=7, then MDR_in+write with bus_in=0xBEEF, then read at ea=7 → MDR=0xBEEF. addr_fault stays 0.
- MAR_in+read with bus_in=0x0010 and DEPTH=16 → MDR=0 and addr_fault=1. A subsequent in-range access still works and addr_fault stays 1.
- Read and write in the same cycle at MAR=2 with bus_in=0x00AA → RAM[2]=0x00AA, MDR=0x00AA, protocol_err=1.
- Assert reset during LOAD after 2 words → all outputs return to reset values immediately. CLEAR restarts and the earlier words read back 0.
